// File: rtl/grn_pkg.sv
// Shared constants and helpers for the GRN node state holder.
package grn_pkg;
  localparam int STAB_CNT_W   = 8;
  localparam int DEF_N_CH     = 2;
  localparam int DEF_STATE_W  = 1;
  localparam int DEF_PERIOD_W = 4;
  localparam int DEF_HIST     = 4;

  // A programmed period of 0 behaves like 1 (commit on every strobe).
  function automatic int unsigned p_eff(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction
endpackage

// File: rtl/grn_node_nch_if.sv
// Bus between the scaffold/convergence logic and the node state holder.
interface grn_node_nch_if #(
  parameter int N_CH     = 2,
  parameter int STATE_W  = 1,
  parameter int PERIOD_W = 4
);
  logic                              reset_nos;
  logic [STATE_W-1:0]                init_state;
  logic [N_CH-1:0][PERIOD_W-1:0]     period;
  logic [N_CH-1:0]                   start;
  logic [N_CH-1:0][STATE_W-1:0]      next_val;
  logic [N_CH-1:0][STATE_W-1:0]      state;
  logic [N_CH-1:0]                   changed;
  logic [N_CH-1:0]                   stable;
  logic                              all_stable;

  modport master (
    output reset_nos, init_state, period, start, next_val,
    input  state, changed, stable, all_stable
  );
  modport slave (
    input  reset_nos, init_state, period, start, next_val,
    output state, changed, stable, all_stable
  );
endinterface

// File: rtl/grn_node_lane.sv
// One simulation lane: state register, skip counter, stability counter.
module grn_node_lane
  import grn_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int HIST_DEPTH = DEF_HIST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reset_nos,
  input  logic [STATE_W-1:0]  init_state,
  input  logic [PERIOD_W-1:0] period,
  input  logic                start,
  input  logic [STATE_W-1:0]  next_val,
  output logic [STATE_W-1:0]  state,
  output logic                changed,
  output logic                stable,
  output logic                stable_nxt
);
  localparam logic [STAB_CNT_W-1:0] HD = STAB_CNT_W'(HIST_DEPTH);

  logic [PERIOD_W-1:0]   cnt, cnt_n;
  logic [STAB_CNT_W-1:0] sc, sc_n;
  logic [STATE_W-1:0]    state_n;
  logic                  chg_n;

  // Next-state: re-init beats strobes; a strobe commits only when the skip count is spent.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sc_n    = sc;
    chg_n   = 1'b0;
    if (reset_nos) begin
      state_n = init_state;
      cnt_n   = '0;
      sc_n    = '0;
    end else if (start) begin
      if (cnt == '0) begin
        state_n = next_val;
        // period is only looked at here, so mid-count edits wait for this reload
        cnt_n   = PERIOD_W'(p_eff(32'(period)) - 32'd1);
        chg_n   = (next_val != state);
        if (chg_n)        sc_n = '0;
        else if (sc < HD) sc_n = sc + 1'b1;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end
  end

  // Exposed so the top can register all_stable in the same cycle as stable.
  assign stable_nxt = (sc_n == HD);

  // Lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      cnt     <= '0;
      sc      <= '0;
      changed <= 1'b0;
      stable  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sc      <= sc_n;
      changed <= chg_n;
      stable  <= stable_nxt;
    end
  end
endmodule

// File: rtl/grn_node_nch.sv
// N_CH-lane GRN node state holder with change pulses and convergence flags.
module grn_node_nch
  import grn_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int HIST_DEPTH = DEF_HIST
) (
  input logic           clk,
  input logic           rst,
  grn_node_nch_if.slave bus
);
  logic [N_CH-1:0][STATE_W-1:0] state_q;
  logic [N_CH-1:0]              changed_q;
  logic [N_CH-1:0]              stable_q;
  logic [N_CH-1:0]              stable_nxt;
  logic                         all_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    grn_node_lane #(
      .STATE_W   (STATE_W),
      .PERIOD_W  (PERIOD_W),
      .HIST_DEPTH(HIST_DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .reset_nos (bus.reset_nos),
      .init_state(bus.init_state),
      .period    (bus.period[i]),
      .start     (bus.start[i]),
      .next_val  (bus.next_val[i]),
      .state     (state_q[i]),
      .changed   (changed_q[i]),
      .stable    (stable_q[i]),
      .stable_nxt(stable_nxt[i])
    );
  end

  // Built from next-state flags so it lines up with the per-lane stable outputs.
  always_ff @(posedge clk) begin
    if (rst) all_q <= 1'b0;
    else     all_q <= &stable_nxt;
  end

  assign bus.state      = state_q;
  assign bus.changed    = changed_q;
  assign bus.stable     = stable_q;
  assign bus.all_stable = all_q;
endmodule
